fp_mult_pipe: RTL and testbench
===============================

# fp_mult_pipe

Parametrised, three-stage pipelined IEEE-754-style floating-point multiplier with valid/ready handshakes on input and output. It is the next generation of the team's single-precision multiplier. It adds:
- configurable exponent and mantissa widths;
- a selectable rounding mode;
- saturation to infinity or max-finite on overflow, instead of a wrapped exponent;
- flush-to-zero on underflow;
- NaN/Inf handling and a full IEEE flag set.

It sits in the arithmetic datapath between an operand producer and a result consumer, and either side may stall.

## Interface
- EXP_W, 8, exponent width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operands x, y, rnd_mode valid.
- in_ready  out  1  block accepts this cycle.
- x  in  W  operand A.
- y  in  W  operand B.
- rnd_mode  in  1  0 = round-nearest-even (RNE), 1 = round-toward-zero (RTZ); sampled with operands.
- out_valid  out  1  product and flags valid.
- out_ready  in  1  consumer accepts this cycle.
- product  out  W  result.
- overflow  out  1  result exponent exceeded range.
- underflow  out  1  nonzero result flushed to zero.
- invalid  out  1  Inf×0 or signalling-NaN operand.
- inexact  out  1  rounding, overflow or flush discarded bits.

## Operation
- Global-enable pipeline: adv = out_ready | ~out_valid; in_ready = adv (combinational).
  - All stages shift together on adv.
  - Bubbles are not squeezed.
  - Accept occurs on in_valid & in_ready.
- S1 (unpack/classify):
  - Split sign, exponent, mantissa.
  - Zero exponent → operand treated as ±0; denormals read as zero.
  - Max exponent → Inf (mantissa 0) or NaN.
  - sign = sx ^ sy.
  - e = ex + ey − BIAS, computed in EXP_W+2-bit signed.
  - Record special class.
- S2 (multiply/normalise):
  - (MAN_W+1)×(MAN_W+1) → 2·MAN_W+2 bit product of hidden-1 mantissas.
  - If MSB is set: shift right 1, e += 1.
  - Form guard bit G and sticky S (OR of all lower bits).
- S3 (round/pack):
  - RNE: increment when G & (S | LSB).
  - RTZ: never increment.
  - Mantissa carry-out → mantissa = 1.0, e += 1.
  - inexact = G | S.
- Range checks, applied after rounding:
  - e ≥ 2^EXP_W−1: overflow = 1, inexact = 1. RNE → ±Inf; RTZ → ±max-finite (exp 2^EXP_W−2, mantissa all-ones).
  - e ≤ 0: result ±0 with computed sign, underflow = 1, inexact = 1.
- Specials override the arithmetic:
  - Any NaN, or Inf×0 → canonical qNaN (sign 0, exp all-ones, mantissa MSB 1, rest 0).
  - invalid = 1 only for Inf×0 or an sNaN input (mantissa MSB 0). A qNaN input raises no flag.
  - Inf × nonzero finite/Inf → ±Inf, no flags.
  - Zero × finite → ±0, no flags.
- Flags are registered alongside product and belong only to the result currently presented.

## Timing
- Latency: 3 cycles. An operand accepted at edge n gives out_valid = 1 after edge n+3 when adv stays high.
- Throughput: one result per cycle when out_ready is held high.
- Stall: out_valid & ~out_ready.
  - product and flags are held stable.
  - in_ready = 0 in the same cycle.
  - No result is lost or duplicated.
- Results are returned in strict acceptance order.
- Reset values (rst high at a clock edge):
  - all stage valid bits 0;
  - out_valid 0, product 0, all flags 0;
  - in_ready = 1 from the following cycle.
- Reset mid-operation discards all in-flight operations; none appear afterwards.
- If rst and in_valid are high in the same cycle, rst wins and the operand is not accepted.

## Test plan
- Latency and basic result (defaults, RNE): x = 0x408a2000, y = 0xc08a2000 → product 0xc1950d08, flags 0, out_valid exactly 3 cycles after accept.
- Streaming and backpressure:
  - Four pairs on consecutive cycles with out_ready = 1 → four results on consecutive cycles, in order. Pairs: 0x408aa000×0x408a2000, 0xc28aa000×0xc10a2000, 0xc28aa000×0x418aa000, 0x418aa000×0x3f800000.
  - Expected products: 0x41959728, 0x44159728, 0xc49621c8, 0x418aa000.
  - Repeat with out_ready low for 5 cycles mid-stream → in_ready low, product stable throughout, no loss.
- Overflow: 0x7f000000 × 0x40000000.
  - RNE → 0x7f800000, overflow = 1, inexact = 1.
  - RTZ → 0x7f7fffff, overflow = 1, inexact = 1.
- Underflow and rounding:
  - 0x00800000 × 0x3f000000 → 0x00000000, underflow = 1, inexact = 1.
  - 0x3f800001 × 0x3f800001 → 0x3f800002, inexact = 1 in both modes.
- Specials:
  - 0x7f800000 × 0x00000000 → 0x7fc00000, invalid = 1.
  - 0xff800000 × 0x40000000 → 0xff800000, no flags.
  - 0x7fc00000 × 0x3f800000 → 0x7fc00000, invalid = 0.
- Reset mid-operation: accept two operations, assert rst for 1 cycle before either emerges → out_valid = 0 for the next 5 cycles, product = 0.

Source files
------------

// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined floating-point multiplier with rounding modes, saturation, flush-to-zero and IEEE flags
module fp_mult_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         rnd_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] product,
  output logic         overflow,
  output logic         underflow,
  output logic         invalid,
  output logic         inexact
);
  localparam int EW = EXP_W + 2;
  localparam int PW = 2 * MAN_W + 2;
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EXP_W-1:0] EMAX_M1 = EMAX - 1'b1;
  localparam logic [EW-1:0] BIAS_E = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic [EW-1:0] ETOP = EW'(2 ** EXP_W - 1);
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  logic adv, v0, v1, v2;
  logic [W-1:0] x0, y0;
  logic rm0;
  logic s1_sign, s1_rm, s1_nan, s1_inv, s1_inf, s1_zero;
  logic [EW-1:0] s1_e;
  logic [MAN_W:0] s1_mx, s1_my;
  logic s2_sign, s2_rm, s2_nan, s2_inv, s2_inf, s2_zero, s2_g, s2_s;
  logic [EW-1:0] s2_e;
  logic [MAN_W-1:0] s2_man;
  assign adv = out_ready | ~out_valid;
  assign in_ready = adv;
  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] mx, my;
  logic zx, zy, ix, iy, nx, ny, snan, ixz;
  assign ex = x0[W-2:MAN_W];
  assign ey = y0[W-2:MAN_W];
  assign mx = x0[MAN_W-1:0];
  assign my = y0[MAN_W-1:0];
  assign zx = ex == '0;
  assign zy = ey == '0;
  assign ix = ex == EMAX && mx == '0;
  assign iy = ey == EMAX && my == '0;
  assign nx = ex == EMAX && mx != '0;
  assign ny = ey == EMAX && my != '0;
  assign snan = (nx & ~mx[MAN_W-1]) | (ny & ~my[MAN_W-1]);
  assign ixz = (ix & zy) | (iy & zx);
  logic [PW-1:0] p, pn;
  assign p = {{(MAN_W+1){1'b0}}, s1_mx} * {{(MAN_W+1){1'b0}}, s1_my};
  assign pn = p[PW-1] ? p : {p[PW-2:0], 1'b0};
  logic inc, c, ovf, unf, spec;
  logic [MAN_W-1:0] mr;
  logic [EW-1:0] er;
  logic [W-1:0] arith, res;
  always_comb begin
    inc = ~s2_rm & s2_g & (s2_s | s2_man[0]);
    {c, mr} = {1'b0, s2_man} + (MAN_W+1)'(inc);
    er = s2_e + {{(EW-1){1'b0}}, c};
    ovf = ~er[EW-1] && er >= ETOP;
    unf = er[EW-1] || er == '0;
    spec = s2_nan | s2_inf | s2_zero;
    arith = ovf ? (s2_rm ? {s2_sign, EMAX_M1, {MAN_W{1'b1}}} : {s2_sign, EMAX, {MAN_W{1'b0}}})
          : unf ? {s2_sign, {(W-1){1'b0}}}
          : {s2_sign, er[EXP_W-1:0], mr};
    res = s2_nan ? QNAN
        : s2_inf ? {s2_sign, EMAX, {MAN_W{1'b0}}}
        : s2_zero ? {s2_sign, {(W-1){1'b0}}}
        : arith;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      out_valid <= 1'b0;
      product <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
      invalid <= 1'b0;
      inexact <= 1'b0;
    end else if (adv) begin
      v0 <= in_valid;
      v1 <= v0;
      v2 <= v1;
      out_valid <= v2;
      if (v2) begin
        product <= res;
        overflow <= ~spec & ovf;
        underflow <= ~spec & unf;
        invalid <= s2_nan & s2_inv;
        inexact <= ~spec & (s2_g | s2_s | ovf | unf);
      end
    end
  end
  // Datapath registers carry no reset; only the valid bits decide what is real.
  always_ff @(posedge clk) begin
    if (adv) begin
      x0 <= x;
      y0 <= y;
      rm0 <= rnd_mode;
      s1_sign <= x0[W-1] ^ y0[W-1];
      s1_e <= {2'b0, ex} + {2'b0, ey} - BIAS_E;
      s1_mx <= {1'b1, mx};
      s1_my <= {1'b1, my};
      s1_rm <= rm0;
      s1_nan <= nx | ny | ixz;
      s1_inv <= snan | ixz;
      s1_inf <= ix | iy;
      s1_zero <= zx | zy;
      s2_sign <= s1_sign;
      s2_e <= s1_e + {{(EW-1){1'b0}}, p[PW-1]};
      s2_man <= pn[PW-2:MAN_W+1];
      s2_g <= pn[MAN_W];
      s2_s <= |pn[MAN_W-1:0];
      s2_rm <= s1_rm;
      s2_nan <= s1_nan;
      s2_inv <= s1_inv;
      s2_inf <= s1_inf & ~s1_nan;
      s2_zero <= s1_zero & ~s1_nan;
    end
  end
endmodule

// File: tb/tb_fp_mult_pipe.sv
// tb_fp_mult_pipe: table-driven check of fp_mult_pipe results, flags, latency, backpressure and reset flush
module tb_fp_mult_pipe;
  logic clk = 0, rst = 1, in_valid = 0, rnd_mode = 0, out_ready = 1;
  logic [31:0] x = 0, y = 0;
  logic in_ready, out_valid, overflow, underflow, invalid, inexact;
  logic [31:0] product;
  logic [3:0] fl;
  assign fl = {overflow, underflow, invalid, inexact};
  fp_mult_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y),
    .rnd_mode(rnd_mode), .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic rm;
    logic [31:0] p;
    logic [3:0] f;
  } vec_t;
  typedef struct {
    vec_t v;
    int t;
  } pend_t;
  vec_t tab[13];
  vec_t cur;
  pend_t q[$];
  pend_t pe;
  int checks = 0, failures = 0, cycle = 0;
  logic lat_chk = 1, stalled = 0;
  logic [35:0] held = 0;
  always @(posedge clk) cycle <= cycle + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cycle);
    end
  endtask
  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at cycle %0d", name, cycle);
  endtask
  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid && stalled) chk("hold", {product, fl}, held);
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (q.size() == 0) fail("extra_output");
        else begin
          pe = q.pop_front();
          chk("product", product, pe.v.p);
          chk("flags", fl, pe.v.f);
          if (lat_chk) chk("latency", cycle - pe.t, 3);
        end
      end
      if (in_valid && in_ready) q.push_back('{cur, cycle + 1});
    end
    stalled = !rst && out_valid && !out_ready;
    held = {product, fl};
  end
  task automatic send(input vec_t v);
    int n = 0;
    x = v.x;
    y = v.y;
    rnd_mode = v.rm;
    cur = v;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) fail("accept_timeout");
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) fail("drain_timeout");
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end
  initial begin
    tab[0]  = '{32'h408a2000, 32'hc08a2000, 1'b0, 32'hc1950d08, 4'b0000};
    tab[1]  = '{32'h408aa000, 32'h408a2000, 1'b0, 32'h41959728, 4'b0000};
    tab[2]  = '{32'hc28aa000, 32'hc10a2000, 1'b0, 32'h44159728, 4'b0000};
    tab[3]  = '{32'hc28aa000, 32'h418aa000, 1'b0, 32'hc49621c8, 4'b0000};
    tab[4]  = '{32'h418aa000, 32'h3f800000, 1'b0, 32'h418aa000, 4'b0000};
    tab[5]  = '{32'h7f000000, 32'h40000000, 1'b0, 32'h7f800000, 4'b1001};
    tab[6]  = '{32'h7f000000, 32'h40000000, 1'b1, 32'h7f7fffff, 4'b1001};
    tab[7]  = '{32'h00800000, 32'h3f000000, 1'b0, 32'h00000000, 4'b0101};
    tab[8]  = '{32'h3f800001, 32'h3f800001, 1'b0, 32'h3f800002, 4'b0001};
    tab[9]  = '{32'h3f800001, 32'h3f800001, 1'b1, 32'h3f800002, 4'b0001};
    tab[10] = '{32'h7f800000, 32'h00000000, 1'b0, 32'h7fc00000, 4'b0010};
    tab[11] = '{32'hff800000, 32'h40000000, 1'b0, 32'hff800000, 4'b0000};
    tab[12] = '{32'h7fc00000, 32'h3f800000, 1'b0, 32'h7fc00000, 4'b0000};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_product", product, 0);
    chk("reset_flags", fl, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) begin
      send(tab[i]);
      drain();
      @(posedge clk);
      #1;
    end
    for (int i = 1; i < 5; i++) send(tab[i]);
    drain();
    @(posedge clk);
    #1 lat_chk = 0;
    fork
      for (int i = 1; i < 5; i++) send(tab[i]);
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    chk("stall_no_loss", q.size(), 0);
    @(posedge clk);
    #1 lat_chk = 1;
    send(tab[0]);
    send(tab[5]);
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
      chk("flush_product", product, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
